// File: rtl/page_replay_buf_if.sv
// Bus bundle between a BFT leaf adapter and page_replay_buf.
// The master side drives packets and control, the slave side is the buffer.
interface page_replay_buf_if #(
    parameter int DATA_W = 49,
    parameter int DEPTH  = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] din_leaf_bft2interface;
    logic [DATA_W-1:0] dout_leaf_interface2bft;
    logic              ap_start;
    logic              resend;
    logic [CW-1:0]     count;
    logic              full;
    logic              busy;
    logic              overflow;

    modport master (
        output din_leaf_bft2interface,
        output ap_start,
        output resend,
        input  dout_leaf_interface2bft,
        input  count,
        input  full,
        input  busy,
        input  overflow
    );

    modport slave (
        input  din_leaf_bft2interface,
        input  ap_start,
        input  resend,
        output dout_leaf_interface2bft,
        output count,
        output full,
        output busy,
        output overflow
    );
endinterface

// File: rtl/page_replay_buf.sv
// Capture/replay buffer for BFT leaf packets.
// While ap_start is high, valid packets (MSB set) are stored in order until
// the buffer is full; a resend request in IDLE replays the stored packets
// back-to-back on dout, one per cycle, without disturbing the contents.
module page_replay_buf #(
    parameter int DATA_W = 49,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    page_replay_buf_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_REPLAY  = 2'd2
    } state_t;

    state_t            state_reg;
    logic [CW-1:0]     count_reg;
    logic [CW-1:0]     rd_ptr_reg;
    logic              overflow_reg;
    logic [DATA_W-1:0] dout_reg;

    // Packet storage; no reset so it maps onto block RAM. Stale entries are
    // harmless because count_reg bounds everything that can be replayed.
    logic [DATA_W-1:0] mem [DEPTH];

    logic              pkt_valid;
    logic              has_room;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;
    logic              replay_more;

    assign pkt_valid   = bus.din_leaf_bft2interface[DATA_W-1];
    assign has_room    = (count_reg < CW'(DEPTH));
    assign wr_addr     = count_reg[AW-1:0];
    assign rd_addr     = rd_ptr_reg[AW-1:0];
    assign replay_more = (rd_ptr_reg < count_reg);

    // The write is gated by ap_start so the exit cycle never captures, and by
    // has_room so a full buffer silently drops (overflow flags it instead).
    assign wr_en = (state_reg == ST_CAPTURE) && bus.ap_start && pkt_valid
                   && has_room && !reset;

    // Store a captured packet at the slot just past the last one held.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= bus.din_leaf_bft2interface;
        end
    end

    // Control FSM with registered dout, count, overflow and read pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            dout_reg     <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            rd_ptr_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    dout_reg <= '0;
                    // ap_start wins over resend; starting a capture discards
                    // the previous page.
                    if (bus.ap_start) begin
                        state_reg    <= ST_CAPTURE;
                        count_reg    <= '0;
                        overflow_reg <= 1'b0;
                    end else if (bus.resend && (count_reg != '0)) begin
                        state_reg  <= ST_REPLAY;
                        rd_ptr_reg <= '0;
                    end
                end

                ST_CAPTURE: begin
                    dout_reg <= '0;
                    if (!bus.ap_start) begin
                        state_reg <= ST_IDLE;
                    end else if (pkt_valid) begin
                        if (has_room) begin
                            count_reg <= count_reg + CW'(1);
                        end else begin
                            overflow_reg <= 1'b1;
                        end
                    end
                end

                ST_REPLAY: begin
                    // One packet per cycle; the cycle after the last packet
                    // drives 0 and hands control back to IDLE.
                    if (replay_more) begin
                        dout_reg   <= mem[rd_addr];
                        rd_ptr_reg <= rd_ptr_reg + CW'(1);
                    end else begin
                        dout_reg   <= '0;
                        rd_ptr_reg <= '0;
                        state_reg  <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    dout_reg  <= '0;
                end
            endcase
        end
    end

    assign bus.dout_leaf_interface2bft = dout_reg;
    assign bus.count                   = count_reg;
    assign bus.overflow                = overflow_reg;
    assign bus.full                    = (count_reg == CW'(DEPTH));
    assign bus.busy                    = (state_reg == ST_REPLAY);

endmodule

// File: tb/tb_page_replay_buf.sv
// Directed bench for page_replay_buf: capture, replay, repeat replay,
// overflow, invalid packets, empty resend, reset mid-replay and priority.
module tb_page_replay_buf;
    localparam int DATA_W = 49;
    localparam int DEPTH  = 16;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [DATA_W-1:0] exp_q [$];

    page_replay_buf_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    page_replay_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] mk_pkt(input logic [15:0] tag);
        return {1'b1, 32'h0, tag};
    endfunction

    task automatic capture_pkt(input logic [DATA_W-1:0] p);
        bus.din_leaf_bft2interface = p;
        step();
    endtask

    // Pulse resend from IDLE and check the expected packet stream in exp_q.
    task automatic run_replay(input int n);
        bus.resend = 1'b1;
        step();
        bus.resend = 1'b0;
        check("rp_enter_busy", 64'(bus.busy), 64'd1);
        check("rp_enter_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
        for (int i = 0; i < n; i++) begin
            step();
            check($sformatf("rp_dout[%0d]", i), 64'(bus.dout_leaf_interface2bft), 64'(exp_q[i]));
            check($sformatf("rp_busy[%0d]", i), 64'(bus.busy), 64'd1);
        end
        step();
        check("rp_end_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
        check("rp_end_busy", 64'(bus.busy), 64'd0);
        check("rp_end_count", 64'(bus.count), 64'(n));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.din_leaf_bft2interface = '0;
        bus.ap_start = 1'b0;
        bus.resend   = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_full", 64'(bus.full), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_ovf", 64'(bus.overflow), 64'd0);

        // Capture three packets A1..A3 and replay them.
        bus.ap_start = 1'b1;
        step();
        exp_q.delete();
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(mk_pkt(16'h00A0 + 16'(i)));
            capture_pkt(mk_pkt(16'h00A0 + 16'(i)));
        end
        bus.din_leaf_bft2interface = '0;
        check("cap3_count", 64'(bus.count), 64'd3);
        check("cap_dout_zero", 64'(bus.dout_leaf_interface2bft), 64'd0);
        // resend during CAPTURE has no effect
        bus.resend = 1'b1;
        step();
        bus.resend = 1'b0;
        check("cap_resend_busy", 64'(bus.busy), 64'd0);
        bus.ap_start = 1'b0;
        step();
        check("idle_count", 64'(bus.count), 64'd3);
        run_replay(3);
        // Non-destructive: same sequence again.
        run_replay(3);

        // Invalid packets during capture leave count alone.
        bus.ap_start = 1'b1;
        step();
        check("recap_count_clr", 64'(bus.count), 64'd0);
        capture_pkt(49'h0_0000_0000_00F1);
        capture_pkt(49'h0_FFFF_FFFF_FFFF);
        check("invalid_count", 64'(bus.count), 64'd0);

        // Overflow: 18 packets, only the first 16 held.
        exp_q.delete();
        for (int i = 1; i <= 18; i++) begin
            if (i <= 16) exp_q.push_back(mk_pkt(16'h0B00 + 16'(i)));
            capture_pkt(mk_pkt(16'h0B00 + 16'(i)));
            if (i == 16) begin
                check("ovf16_full", 64'(bus.full), 64'd1);
                check("ovf16_flag", 64'(bus.overflow), 64'd0);
            end
        end
        bus.din_leaf_bft2interface = '0;
        check("ovf_count", 64'(bus.count), 64'd16);
        check("ovf_full", 64'(bus.full), 64'd1);
        check("ovf_flag", 64'(bus.overflow), 64'd1);
        bus.ap_start = 1'b0;
        step();
        run_replay(16);
        check("ovf_sticky", 64'(bus.overflow), 64'd1);

        // New capture clears overflow; hold 4 packets for the priority case.
        bus.ap_start = 1'b1;
        step();
        check("newcap_ovf_clr", 64'(bus.overflow), 64'd0);
        for (int i = 1; i <= 4; i++) capture_pkt(mk_pkt(16'h0D00 + 16'(i)));
        bus.din_leaf_bft2interface = '0;
        bus.ap_start = 1'b0;
        step();
        check("pri_pre_count", 64'(bus.count), 64'd4);
        bus.ap_start = 1'b1;
        bus.resend   = 1'b1;
        step();
        bus.resend = 1'b0;
        check("pri_busy", 64'(bus.busy), 64'd0);
        check("pri_count", 64'(bus.count), 64'd0);
        step();
        check("pri_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
        check("pri_busy2", 64'(bus.busy), 64'd0);
        bus.ap_start = 1'b0;
        step();

        // Resend with an empty buffer does nothing.
        bus.resend = 1'b1;
        step();
        bus.resend = 1'b0;
        check("empty_busy", 64'(bus.busy), 64'd0);
        check("empty_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
        step();
        check("empty_dout2", 64'(bus.dout_leaf_interface2bft), 64'd0);

        // Reset during replay of 5 packets, after the second packet appears.
        bus.ap_start = 1'b1;
        step();
        exp_q.delete();
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(mk_pkt(16'h00C0 + 16'(i)));
            capture_pkt(mk_pkt(16'h00C0 + 16'(i)));
        end
        bus.din_leaf_bft2interface = '0;
        bus.ap_start = 1'b0;
        step();
        bus.resend = 1'b1;
        step();
        bus.resend = 1'b0;
        step();
        check("rr_dout0", 64'(bus.dout_leaf_interface2bft), 64'(exp_q[0]));
        step();
        check("rr_dout1", 64'(bus.dout_leaf_interface2bft), 64'(exp_q[1]));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rr_dout_rst", 64'(bus.dout_leaf_interface2bft), 64'd0);
        check("rr_count_rst", 64'(bus.count), 64'd0);
        check("rr_busy_rst", 64'(bus.busy), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("rr_quiet[%0d]", i), 64'(bus.dout_leaf_interface2bft), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
